load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 42 ++++
 rtl/load_formatter.sv | 33 +++
 rtl/load_store_unit.sv | 141 ++++++++++++++
 tb/tb_load_store_unit.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, RV32I size
// encodings, and store-side byte-enable / write-data formatting.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic logic f3_legal(input logic [2:0] f3, input logic [1:0] lane);
        case (f3)
            F3_B, F3_BU: f3_legal = 1'b1;
            F3_H, F3_HU: f3_legal = ~lane[0];
            F3_W:        f3_legal = (lane == 2'b00);
            default:     f3_legal = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] make_be(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            2'b00:   make_be = 4'b0001 << lane;
            2'b01:   make_be = 4'b0011 << lane;
            default: make_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] make_wdata(input logic [1:0] size, input logic [31:0] wd);
        case (size)
            2'b00:   make_wdata = {4{wd[7:0]}};
            2'b01:   make_wdata = {2{wd[15:0]}};
            default: make_wdata = wd;
        endcase
    endfunction

endpackage

// File: rtl/load_formatter.sv
// Selects the addressed byte/halfword lane of a bus read word and
// sign- or zero-extends it according to the load's Funct3.
module load_formatter
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  lane,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (lane)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = lane[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   data = {24'b0, byte_sel};
            F3_H:    data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   data = {16'b0, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// M-stage load/store unit: issues one bus transaction per access, stalls the
// pipeline until the response, and formats load data for writeback.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemReadM,
    input  logic              MemWriteM,
    input  logic [2:0]        Funct3M,
    input  logic [ADDR_W-1:0] ALUResultM,
    input  logic [31:0]       WriteDataM,
    output logic              StallM,
    output logic [31:0]       RdataM,
    output logic              MisalignM,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic              bus_gnt,
    input  logic              bus_rvalid,
    input  logic [31:0]       bus_rdata
);

    lsu_state_t        state;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [3:0]        req_be;
    logic [31:0]       req_wdata;
    logic [2:0]        req_f3;
    logic [1:0]        req_lane;
    logic [31:0]       rdata_q;
    logic [31:0]       fmt_data;

    logic              access;
    logic              legal;
    logic [ADDR_W-1:0] new_addr;
    logic [3:0]        new_be;
    logic [31:0]       new_wdata;
    logic              load_done;

    assign access    = MemReadM | MemWriteM;
    assign legal     = f3_legal(Funct3M, ALUResultM[1:0]);
    assign new_addr  = {ALUResultM[ADDR_W-1:2], 2'b00};
    assign new_be    = make_be(Funct3M[1:0], ALUResultM[1:0]);
    assign new_wdata = make_wdata(Funct3M[1:0], WriteDataM);
    assign load_done = (state == WAIT) && bus_rvalid && !req_we;

    load_formatter u_fmt (
        .funct3 (req_f3),
        .lane   (req_lane),
        .rdata  (bus_rdata),
        .data   (fmt_data)
    );

    // Bypass the capture register in the response cycle so WB sees the data without an extra stall.
    assign RdataM = load_done ? fmt_data : rdata_q;

    always_comb begin
        bus_req   = 1'b0;
        bus_we    = 1'b0;
        bus_addr  = '0;
        bus_be    = 4'b0;
        bus_wdata = 32'b0;
        StallM    = 1'b0;
        MisalignM = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (access && legal) begin
                        bus_req   = 1'b1;
                        StallM    = 1'b1;
                        bus_we    = MemWriteM;
                        bus_addr  = new_addr;
                        bus_be    = new_be;
                        bus_wdata = new_wdata;
                    end else if (access) begin
                        MisalignM = 1'b1;
                    end
                end
                REQ: begin
                    bus_req   = 1'b1;
                    StallM    = 1'b1;
                    bus_we    = req_we;
                    bus_addr  = req_addr;
                    bus_be    = req_be;
                    bus_wdata = req_wdata;
                end
                WAIT: begin
                    StallM    = ~bus_rvalid;
                    bus_we    = req_we;
                    bus_addr  = req_addr;
                    bus_be    = req_be;
                    bus_wdata = req_wdata;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            req_we    <= 1'b0;
            req_addr  <= '0;
            req_be    <= 4'b0;
            req_wdata <= 32'b0;
            req_f3    <= 3'b0;
            req_lane  <= 2'b0;
            rdata_q   <= 32'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (access && legal) begin
                        req_we    <= MemWriteM;
                        req_addr  <= new_addr;
                        req_be    <= new_be;
                        req_wdata <= new_wdata;
                        req_f3    <= Funct3M;
                        req_lane  <= ALUResultM[1:0];
                        state     <= bus_gnt ? WAIT : REQ;
                    end
                end
                REQ: begin
                    if (bus_gnt) state <= WAIT;
                end
                WAIT: begin
                    if (bus_rvalid) begin
                        state <= IDLE;
                        if (!req_we) rdata_q <= fmt_data;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: loads, stores, misalignment and reset
// mid-transaction, each checked against hand-computed values.
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        MemReadM;
    logic        MemWriteM;
    logic [2:0]  Funct3M;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic        StallM;
    logic [31:0] RdataM;
    logic        MisalignM;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    int passed = 0;
    int total  = 0;

    load_store_unit #(.ADDR_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .Funct3M    (Funct3M),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .StallM     (StallM),
        .RdataM     (RdataM),
        .MisalignM  (MisalignM),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_be     (bus_be),
        .bus_wdata  (bus_wdata),
        .bus_gnt    (bus_gnt),
        .bus_rvalid (bus_rvalid),
        .bus_rdata  (bus_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic idle_inputs();
        MemReadM   = 1'b0;
        MemWriteM  = 1'b0;
        Funct3M    = 3'b000;
        ALUResultM = 32'h0;
        WriteDataM = 32'h0;
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b0;
        bus_rdata  = 32'h0;
    endtask

    // Load with grant in the request cycle and response one cycle later.
    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rd, input logic [31:0] exp_rd,
                           input logic [3:0] exp_be, input logic [31:0] exp_addr);
        @(negedge clk);
        MemReadM = 1'b1; Funct3M = f3; ALUResultM = addr; bus_gnt = 1'b1;
        #1;
        chk({tag, "_req"},   bus_req, 32'd1);
        chk({tag, "_we"},    bus_we, 32'd0);
        chk({tag, "_stall"}, StallM, 32'd1);
        chk({tag, "_be"},    bus_be, exp_be);
        chk({tag, "_addr"},  bus_addr, exp_addr);
        @(negedge clk);
        bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = rd;
        #1;
        chk({tag, "_stall_rv"}, StallM, 32'd0);
        chk({tag, "_rdata_rv"}, RdataM, exp_rd);
        @(negedge clk);
        idle_inputs();
        #1;
        chk({tag, "_rdata_hold"}, RdataM, exp_rd);
        chk({tag, "_req_idle"},   bus_req, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        MemReadM = 1'b1; Funct3M = 3'b010; ALUResultM = 32'h100;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_stall",    StallM, 32'd0);
        chk("rst_rdata",    RdataM, 32'd0);
        chk("rst_req",      bus_req, 32'd0);
        chk("rst_be",       bus_be, 32'd0);
        chk("rst_addr",     bus_addr, 32'd0);
        chk("rst_misalign", MisalignM, 32'd0);

        @(negedge clk);
        rst = 1'b0;
        idle_inputs();

        do_load("lw100",  3'b010, 32'h100, 32'hDEADBEEF, 32'hDEADBEEF, 4'b1111, 32'h100);
        do_load("lb103",  3'b000, 32'h103, 32'h80112233, 32'hFFFFFF80, 4'b1000, 32'h100);
        do_load("lbu103", 3'b100, 32'h103, 32'h80112233, 32'h00000080, 4'b1000, 32'h100);
        do_load("lhu102", 3'b101, 32'h102, 32'h80112233, 32'h00008011, 4'b1100, 32'h100);

        // SH at 0x102, grant withheld three cycles; a stray rvalid in REQ is ignored.
        @(negedge clk);
        MemWriteM = 1'b1; Funct3M = 3'b001; ALUResultM = 32'h102; WriteDataM = 32'h0000ABCD;
        for (int c = 0; c < 4; c++) begin
            if (c == 1) begin bus_rvalid = 1'b1; bus_rdata = 32'h5555AAAA; end
            if (c == 2) bus_rvalid = 1'b0;
            if (c == 3) bus_gnt = 1'b1;
            #1;
            chk($sformatf("sh_req_c%0d", c),   bus_req, 32'd1);
            chk($sformatf("sh_we_c%0d", c),    bus_we, 32'd1);
            chk($sformatf("sh_be_c%0d", c),    bus_be, 32'hC);
            chk($sformatf("sh_wdata_c%0d", c), bus_wdata, 32'hABCDABCD);
            chk($sformatf("sh_addr_c%0d", c),  bus_addr, 32'h100);
            chk($sformatf("sh_stall_c%0d", c), StallM, 32'd1);
            chk($sformatf("sh_rdata_c%0d", c), RdataM, 32'h00008011);
            @(negedge clk);
        end
        bus_gnt = 1'b0;
        #1;
        chk("sh_wait_stall", StallM, 32'd1);
        chk("sh_wait_req",   bus_req, 32'd0);
        @(negedge clk);
        bus_rvalid = 1'b1; bus_rdata = 32'h12345678;
        #1;
        chk("sh_ack_stall", StallM, 32'd0);
        chk("sh_ack_rdata", RdataM, 32'h00008011);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("sh_after_rdata", RdataM, 32'h00008011);

        // Misaligned LW at 0x101.
        @(negedge clk);
        MemReadM = 1'b1; Funct3M = 3'b010; ALUResultM = 32'h101; bus_gnt = 1'b1;
        #1;
        chk("mis_lw_pulse", MisalignM, 32'd1);
        chk("mis_lw_req",   bus_req, 32'd0);
        chk("mis_lw_stall", StallM, 32'd0);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("mis_lw_pulse_end", MisalignM, 32'd0);
        chk("mis_lw_rdata",     RdataM, 32'h00008011);

        // Reserved Funct3 (011) and misaligned halfword.
        @(negedge clk);
        MemReadM = 1'b1; Funct3M = 3'b011; ALUResultM = 32'h100;
        #1;
        chk("rsv_f3_pulse", MisalignM, 32'd1);
        chk("rsv_f3_req",   bus_req, 32'd0);
        @(negedge clk);
        MemReadM = 1'b0; MemWriteM = 1'b1; Funct3M = 3'b001; ALUResultM = 32'h103;
        #1;
        chk("mis_sh_pulse", MisalignM, 32'd1);
        chk("mis_sh_stall", StallM, 32'd0);
        @(negedge clk);
        idle_inputs();

        // Read and write together: treated as a store.
        @(negedge clk);
        MemReadM = 1'b1; MemWriteM = 1'b1; Funct3M = 3'b010;
        ALUResultM = 32'h200; WriteDataM = 32'h11223344; bus_gnt = 1'b1;
        #1;
        chk("both_we",    bus_we, 32'd1);
        chk("both_req",   bus_req, 32'd1);
        chk("both_wdata", bus_wdata, 32'h11223344);
        chk("both_be",    bus_be, 32'hF);
        @(negedge clk);
        bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hFFFFFFFF;
        #1;
        chk("both_ack_stall", StallM, 32'd0);
        chk("both_rdata",     RdataM, 32'h00008011);
        @(negedge clk);
        idle_inputs();

        // Reset while waiting for the response.
        @(negedge clk);
        MemReadM = 1'b1; Funct3M = 3'b010; ALUResultM = 32'h300; bus_gnt = 1'b1;
        @(negedge clk);
        bus_gnt = 1'b0;
        #1;
        chk("rw_wait_stall", StallM, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rw_stall",    StallM, 32'd0);
        chk("rw_req",      bus_req, 32'd0);
        chk("rw_we",       bus_we, 32'd0);
        chk("rw_be",       bus_be, 32'd0);
        chk("rw_addr",     bus_addr, 32'd0);
        chk("rw_wdata",    bus_wdata, 32'd0);
        chk("rw_misalign", MisalignM, 32'd0);
        chk("rw_rdata",    RdataM, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        bus_rvalid = 1'b1; bus_rdata = 32'hCAFEF00D;
        #1;
        chk("rw_late_rdata", RdataM, 32'd0);
        chk("rw_late_stall", StallM, 32'd0);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("rw_after_rdata", RdataM, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
